keypad_entry_reader: RTL
========================

// Module: keypad_entry_reader
// PURPOSE
//  Input-side counterpart of the 7-seg display multiplexer: scans a 4x4 matrix keypad by driving columns and reading rows.
//  Debounces keypresses and assembles up to 3 decimal digits into a binary operand (0..999) for the adder.
//  Delivers each operand through a valid/ready handshake. Exposes the live entry value so the display path can echo typing.
// PARAMETERS
//  SCAN_DIV        27000  clk cycles per column slot; rows sampled on last cycle of slot
//  DEBOUNCE_SCANS  4      consecutive identical samples required for press and for release
//  N_DIGITS        3      max digits per operand; widths below assume 3 (10-bit value)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-low reset
//  row_in        in   4   keypad rows, pulled up, active-low, asynchronous
//  col_out       out  4   column drive, active-low one-hot
//  key_event     out  1   1-cycle pulse per debounced press
//  key_code      out  4   code of last debounced key (valid with key_event)
//  entry_value   out  10  binary value being typed
//  digit_count   out  2   digits typed so far (0..3)
//  number_out    out  10  committed operand
//  number_valid  out  1   number_out available
//  number_ready  in   1   consumer accepts; transfer when valid && ready
// BEHAVIOUR
//  Reset (async, active-low): col_out=4'b1110, key_event=0, key_code=0, entry_value=0, digit_count=0, number_out=0, number_valid=0; scanner FSM -> SCAN.
//  row_in passes through a 2-flop synchronizer before any use.
//  Key map (row r, col c): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D.
//  Codes: digits 0..9 = 4'h0..4'h9, A..D = 4'hA..4'hD, '*' = 4'hE (CLEAR), '#' = 4'hF (ENTER).
//  Scanner FSM:
//   SCAN: rotate active column 0->1->2->3->0 every SCAN_DIV cycles. Sample rows at slot end.
//    Exactly one row low -> latch (row,col), go to DEBOUNCE with column frozen, match count=1.
//    Zero or >1 rows low -> no action.
//   DEBOUNCE: sample every SCAN_DIV cycles. Same single row low -> count++. Anything else -> SCAN, resume rotation at next column.
//    At count==DEBOUNCE_SCANS: pulse key_event with key_code on the next cycle, go to WAIT_RELEASE.
//   WAIT_RELEASE: column stays frozen. Need DEBOUNCE_SCANS consecutive all-high samples, then SCAN at next column.
//    Any low sample resets the release count. No auto-repeat.
//  Entry logic (cycle after key_event):
//   digit with digit_count<N_DIGITS: entry_value = entry_value*10 + d, computed as (v<<3)+(v<<1)+d, 10-bit, max 999; digit_count++.
//   digit with digit_count==N_DIGITS: ignored.
//   CLEAR: entry_value=0, digit_count=0. A pending number_out is unaffected.
//   ENTER with digit_count>0 and !number_valid: number_out=entry_value, number_valid=1; entry cleared in the same cycle.
//   ENTER with digit_count==0 or number_valid already 1: ignored; entry is preserved.
//   A..D: ignored.
//  Handshake: number_valid and number_out stay stable until a cycle with number_ready=1; number_valid drops on the next edge.
//   ENTER arriving in that same handshake cycle is still ignored (valid sampled before clear).
//  Latency: key_event rises 1 cycle after the DEBOUNCE_SCANS-th matching sample. Entry and valid update 1 cycle after key_event.
//  Reset mid-operation: all state is abandoned immediately, including a partial debounce and a pending number.
// STRUCTURE
//  keypad_pkg: key code localparams (KEY_CLEAR=4'hE, KEY_ENTER=4'hF), scanner state enum, key-map function (row,col)->code.
//  Sub-module keypad_scanner owns synchronizer, column rotation, debounce FSM, key_event and key_code.
//  Top module owns entry accumulator and output handshake.
// TESTING  (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2; keypad model pulls row low when its column is driven)
//  1 reset low mid-scan -> col_out=1110, all outputs 0. Release -> col_out rotates 1110,1101,1011,0111 every 4 cycles.
//  2 press 1,2,# (each held >=3 scans, released) -> 3 key_events, codes 1,2,F. number_out=12 and valid held until ready=1, then valid=0.
//  3 press 9,9,9,5,# -> entry_value stays 999 after 4th digit, digit_count=3. number_out=999; entry cleared to 0.
//  4 row glitch lasting 1 sample, two rows low simultaneously, key A -> no key_event for the first two; A gives key_event but value unchanged.
//  5 press 4,*,7,# -> number_out=7. Then # alone -> no number_valid.
//  6 ready=0: enter 12# then 34# -> valid holds 12, entry_value stays 34; assert reset during a DEBOUNCE state -> everything 0, no key_event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, scanner state encoding and the physical keypad layout
// for the keypad entry path.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } scan_state_e;

  // Rows top to bottom: 1 2 3 A | 4 5 6 B | 7 8 9 C | * 0 # D
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = KEY_CLEAR;
      4'hD:    code = 4'h0;
      4'hE:    code = KEY_ENTER;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with row synchronizer, press/release debounce and a
// one-cycle key_event pulse carrying the decoded key code.
//
// state           | meaning
// ST_SCAN         | rotate columns, look for a single low row
// ST_DEBOUNCE     | column frozen, counting identical single-row samples
// ST_WAIT_RELEASE | column frozen, counting all-high samples
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q, row_q;
  logic [CNT_W-1:0] cnt_q;
  scan_state_e      state_q;
  logic             key_event_q;
  logic [3:0]       key_code_q;

  logic       tick;
  logic       one_low;
  logic [1:0] low_row;

  assign tick = (div_q == '0);

  always_comb begin
    one_low = 1'b1;
    low_row = 2'd0;
    case (row_s2_q)
      4'b1110: low_row = 2'd0;
      4'b1101: low_row = 2'd1;
      4'b1011: low_row = 2'd2;
      4'b0111: low_row = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      div_q       <= DIV_LAST;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      state_q     <= ST_SCAN;
      key_event_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      row_s1_q    <= row_in;
      row_s2_q    <= row_s1_q;
      div_q       <= tick ? DIV_LAST : div_q - 1'b1;
      key_event_q <= 1'b0;
      if (tick) begin
        case (state_q)
          ST_SCAN: begin
            if (one_low) begin
              row_q   <= low_row;
              cnt_q   <= CNT_W'(1);
              state_q <= ST_DEBOUNCE;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
          ST_DEBOUNCE: begin
            if (one_low && (low_row == row_q)) begin
              if (cnt_q == CNT_LAST) begin
                key_event_q <= 1'b1;
                key_code_q  <= key_map(row_q, col_q);
                cnt_q       <= '0;
                state_q     <= ST_WAIT_RELEASE;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              state_q <= ST_SCAN;
              col_q   <= col_q + 1'b1;
            end
          end
          ST_WAIT_RELEASE: begin
            // Any low row restarts the release count; no auto-repeat.
            if (row_s2_q == 4'hF) begin
              if (cnt_q == CNT_LAST) begin
                state_q <= ST_SCAN;
                col_q   <= col_q + 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: state_q <= ST_SCAN;
        endcase
      end
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_event = key_event_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_entry_reader.sv
// Keypad front end: scanner plus decimal entry accumulator and a
// valid/ready handshake delivering each committed operand.
module keypad_entry_reader
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int N_DIGITS       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_event,
  output logic [3:0] key_code,
  output logic [9:0] entry_value,
  output logic [1:0] digit_count,
  output logic [9:0] number_out,
  output logic       number_valid,
  input  logic       number_ready
);

  logic       ev;
  logic [3:0] code;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scanner (
    .clk      (clk),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_event(ev),
    .key_code (code)
  );

  logic [9:0] value_q, value_d;
  logic [1:0] count_q, count_d;
  logic [9:0] num_q, num_d;
  logic       valid_q, valid_d;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    num_d   = num_q;
    valid_d = valid_q;
    if (valid_q && number_ready) valid_d = 1'b0;
    if (ev) begin
      if (code <= 4'd9) begin
        if (count_q < 2'(N_DIGITS)) begin
          // v*10 + d without a multiplier
          value_d = {value_q[6:0], 3'b000} + {value_q[8:0], 1'b0} + {6'b0, code};
          count_d = count_q + 1'b1;
        end
      end else if (code == KEY_CLEAR) begin
        value_d = '0;
        count_d = '0;
      end else if (code == KEY_ENTER && count_q != 2'd0 && !valid_q) begin
        // valid_q is the pre-handshake value, so ENTER during a transfer is dropped
        num_d   = value_q;
        valid_d = 1'b1;
        value_d = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      count_q <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
      num_q   <= num_d;
      valid_q <= valid_d;
    end
  end

  assign key_event    = ev;
  assign key_code     = code;
  assign entry_value  = value_q;
  assign digit_count  = count_q;
  assign number_out   = num_q;
  assign number_valid = valid_q;

endmodule
